// File: rtl/alu_pkg.sv
// Shared ALU control codes, opcode/funct constants and the operand record
// passed from the operand stage into the ALU.
package alu_pkg;

    localparam int XLEN = 32;

    typedef logic [3:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_AND     = 4'b0000;
    localparam alu_ctrl_t ALU_ADD     = 4'b0001;
    localparam alu_ctrl_t ALU_SUB     = 4'b0010;
    localparam alu_ctrl_t ALU_OR      = 4'b0011;
    localparam alu_ctrl_t ALU_SLL     = 4'b0101;
    localparam alu_ctrl_t ALU_SRL     = 4'b0110;
    localparam alu_ctrl_t ALU_SRA     = 4'b1000;
    localparam alu_ctrl_t ALU_SLT     = 4'b1001;
    localparam alu_ctrl_t ALU_ILLEGAL = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        alu_ctrl_t       ctrl;
        logic            illegal;
    } alu_op_t;

    // Occupancy of the two-entry output buffer (main register + skid register).
    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_TWO
    } buf_state_t;

    function automatic logic [XLEN-1:0] sign_ext16(input logic [15:0] value);
        return {{(XLEN-16){value[15]}}, value};
    endfunction

    function automatic logic [XLEN-1:0] zero_ext16(input logic [15:0] value);
        return {{(XLEN-16){1'b0}}, value};
    endfunction

    function automatic alu_op_t make_op(input logic [XLEN-1:0] a,
                                        input logic [XLEN-1:0] b,
                                        input alu_ctrl_t       ctrl);
        alu_op_t op;
        op.a       = a;
        op.b       = b;
        op.ctrl    = ctrl;
        op.illegal = 1'b0;
        return op;
    endfunction

endpackage

// File: rtl/alu_operand_decode.sv
// Combinational decode of instruction fields and register data into the
// ALU operand record {A, B, ctrl, illegal}.
module alu_operand_decode
    import alu_pkg::*;
#(
    parameter logic [3:0] ILLEGAL_CTRL = ALU_ILLEGAL
) (
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic [4:0]      shamt,
    input  logic [15:0]     imm16,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    output alu_op_t         op
);

    alu_op_t         illegal_op;
    logic [XLEN-1:0] shamt_ext;

    assign illegal_op = '{a: '0, b: '0, ctrl: ILLEGAL_CTRL, illegal: 1'b1};
    assign shamt_ext  = {{(XLEN-5){1'b0}}, shamt};

    always_comb begin
        // NOTE: op gets a default before the case so no path leaves it unassigned (no latch).
        op = illegal_op;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_AND:  op = make_op(rs_data, rt_data, ALU_AND);
                    FN_ADD:  op = make_op(rs_data, rt_data, ALU_ADD);
                    FN_SUB:  op = make_op(rs_data, rt_data, ALU_SUB);
                    FN_OR:   op = make_op(rs_data, rt_data, ALU_OR);
                    FN_SLT:  op = make_op(rs_data, rt_data, ALU_SLT);
                    // Shifts take the amount on A and the value on B.
                    FN_SLL:  op = make_op(shamt_ext, rt_data, ALU_SLL);
                    FN_SRL:  op = make_op(shamt_ext, rt_data, ALU_SRL);
                    FN_SRA:  op = make_op(shamt_ext, rt_data, ALU_SRA);
                    default: op = illegal_op;
                endcase
            end
            OP_ADDI: op = make_op(rs_data, sign_ext16(imm16), ALU_ADD);
            OP_ANDI: op = make_op(rs_data, zero_ext16(imm16), ALU_AND);
            default: op = illegal_op;
        endcase
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Registered operand-select / ALU-control stage with a two-entry skid buffer;
// in_ready depends only on buffer state and reset, never on out_ready.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int         WIDTH        = 32,
    parameter logic [3:0] ILLEGAL_CTRL = 4'b1111
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [4:0]       shamt,
    input  logic [15:0]      imm16,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] MuxOutA,
    output logic [WIDTH-1:0] MuxOutB,
    output logic [3:0]       ALUCtrlOut,
    output logic             out_illegal
);

    buf_state_t state_q, state_d;
    alu_op_t    dec_op, main_q, skid_q;
    logic       accept, transfer;
    logic       load_main_in, load_main_skid, load_skid;

    alu_operand_decode #(
        .ILLEGAL_CTRL(ILLEGAL_CTRL)
    ) u_decode (
        .opcode (opcode),
        .funct  (funct),
        .shamt  (shamt),
        .imm16  (imm16),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .op     (dec_op)
    );

    assign in_ready  = (state_q != BUF_TWO) && !reset;
    assign out_valid = (state_q != BUF_EMPTY);
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;

    // State register; flush wins over any accept or transfer this cycle.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (reset || flush) begin
            state_q <= BUF_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BUF_EMPTY: if (accept) state_d = BUF_ONE;
            BUF_ONE: begin
                if (accept && !transfer) begin
                    state_d = BUF_TWO;
                end else if (!accept && transfer) begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_TWO: if (transfer) state_d = BUF_ONE;
            default: state_d = BUF_EMPTY;
        endcase
    end

    always_comb begin
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_q)
            BUF_EMPTY: load_main_in = accept;
            BUF_ONE: begin
                load_main_in = accept && out_ready;
                load_skid    = accept && !out_ready;
            end
            BUF_TWO: load_main_skid = out_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: the data registers are reset because their contents are visible on the outputs.
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            if (load_main_in) begin
                main_q <= dec_op;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec_op;
            end
        end
    end

    assign MuxOutA     = main_q.a;
    assign MuxOutB     = main_q.b;
    assign ALUCtrlOut  = main_q.ctrl;
    assign out_illegal = main_q.illegal;

    // A stalled output must not change until it is taken.
    a_hold_when_stalled: assert property (
        @(posedge clock) disable iff (reset)
        out_valid && !out_ready && !flush |=>
            out_valid && $stable({MuxOutA, MuxOutB, ALUCtrlOut, out_illegal})
    );

    a_no_ready_when_full: assert property (
        @(posedge clock) disable iff (reset)
        (state_q == BUF_TWO) |-> !in_ready
    );

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed vector table, stall and
// flush/reset sequences, and a long random valid/ready run against a decode model.
module tb_alu_operand_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic [4:0]  shamt = '0;
    logic [15:0] imm16 = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] MuxOutA;
    logic [31:0] MuxOutB;
    logic [3:0]  ALUCtrlOut;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    logic [68:0] sb[$];

    alu_operand_stage #(
        .WIDTH(32),
        .ILLEGAL_CTRL(4'b1111)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .funct      (funct),
        .shamt      (shamt),
        .imm16      (imm16),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .MuxOutA    (MuxOutA),
        .MuxOutB    (MuxOutB),
        .ALUCtrlOut (ALUCtrlOut),
        .out_illegal(out_illegal)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference decode written directly from the opcode/funct table.
    function automatic logic [68:0] model(input logic [5:0] opc, input logic [5:0] fn,
                                          input logic [4:0] sh, input logic [15:0] imm,
                                          input logic [31:0] rs, input logic [31:0] rt);
        logic [31:0] a = 32'd0;
        logic [31:0] b = 32'd0;
        logic [3:0]  c = 4'b1111;
        logic        ill = 1'b1;
        if (opc == 6'h00) begin
            ill = 1'b0;
            a = rs;
            b = rt;
            case (fn)
                6'h24: c = 4'b0000;
                6'h20: c = 4'b0001;
                6'h22: c = 4'b0010;
                6'h25: c = 4'b0011;
                6'h2A: c = 4'b1001;
                6'h00: begin c = 4'b0101; a = {27'd0, sh}; end
                6'h02: begin c = 4'b0110; a = {27'd0, sh}; end
                6'h03: begin c = 4'b1000; a = {27'd0, sh}; end
                default: begin ill = 1'b1; a = 32'd0; b = 32'd0; c = 4'b1111; end
            endcase
        end else if (opc == 6'h08) begin
            ill = 1'b0; a = rs; b = {{16{imm[15]}}, imm}; c = 4'b0001;
        end else if (opc == 6'h0C) begin
            ill = 1'b0; a = rs; b = {16'd0, imm}; c = 4'b0000;
        end
        return {a, b, c, ill};
    endfunction

    // Scoreboard: push on accept, pop and compare on transfer.
    always @(negedge clock) begin
        if (reset || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_spurious_output", 1, 0);
                end else begin
                    check("sb_op", {MuxOutA, MuxOutB, ALUCtrlOut, out_illegal}, sb.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(opcode, funct, shamt, imm16, rs_data, rt_data));
            end
        end
    end

    task automatic set_fields(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                              input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
        opcode = opc; funct = fn; shamt = sh; imm16 = imm; rs_data = rs; rt_data = rt;
    endtask

    task automatic set_add(input logic [31:0] rs, input logic [31:0] rt);
        set_fields(6'h00, 6'h20, 5'd0, 16'd0, rs, rt);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic randomize_fields();
        logic [5:0] fn_list [8];
        fn_list = '{6'h24, 6'h20, 6'h22, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h03};
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: begin
                opcode = 6'h00;
                funct = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 7)];
            end
            6:       begin opcode = 6'h08; funct = 6'($urandom); end
            7:       begin opcode = 6'h0C; funct = 6'($urandom); end
            default: begin opcode = 6'($urandom); funct = 6'($urandom); end
        endcase
        shamt = 5'($urandom);
        imm16 = 16'($urandom);
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    typedef struct {
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic        ill;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin
        int accepted;
        int cycles;
        logic last_acc;

        vecs[0]  = '{6'h00, 6'h20, 5'd0,  16'h0000, 32'd5,        32'd7,        32'd5,        32'd7,        4'b0001, 1'b0};
        vecs[1]  = '{6'h08, 6'h00, 5'd0,  16'hFFFF, 32'h10,       32'h0,        32'h10,       32'hFFFFFFFF, 4'b0001, 1'b0};
        vecs[2]  = '{6'h0C, 6'h00, 5'd0,  16'hFFFF, 32'h1234,     32'h0,        32'h1234,     32'h0000FFFF, 4'b0000, 1'b0};
        vecs[3]  = '{6'h00, 6'h03, 5'd4,  16'h0000, 32'hDEAD,     32'h80000000, 32'h4,        32'h80000000, 4'b1000, 1'b0};
        vecs[4]  = '{6'h23, 6'h20, 5'd3,  16'h1234, 32'h55,       32'h66,       32'h0,        32'h0,        4'b1111, 1'b1};
        vecs[5]  = '{6'h00, 6'h22, 5'd0,  16'h0000, 32'd9,        32'd3,        32'd9,        32'd3,        4'b0010, 1'b0};
        vecs[6]  = '{6'h00, 6'h24, 5'd0,  16'h0000, 32'hF0,       32'h3C,       32'hF0,       32'h3C,       4'b0000, 1'b0};
        vecs[7]  = '{6'h00, 6'h25, 5'd0,  16'h0000, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hA5A5A5A5, 32'h5A5A5A5A, 4'b0011, 1'b0};
        vecs[8]  = '{6'h00, 6'h2A, 5'd0,  16'h0000, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 32'h1,        4'b1001, 1'b0};
        vecs[9]  = '{6'h00, 6'h00, 5'd31, 16'h0000, 32'h77,       32'h1,        32'h1F,       32'h1,        4'b0101, 1'b0};
        vecs[10] = '{6'h00, 6'h02, 5'd0,  16'h0000, 32'h77,       32'hF000000F, 32'h0,        32'hF000000F, 4'b0110, 1'b0};
        vecs[11] = '{6'h00, 6'h21, 5'd2,  16'h0000, 32'h11,       32'h22,       32'h0,        32'h0,        4'b1111, 1'b1};
        vecs[12] = '{6'h08, 6'h00, 5'd0,  16'h7FFF, 32'h0,        32'h0,        32'h0,        32'h00007FFF, 4'b0001, 1'b0};

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_outputs", {MuxOutA, MuxOutB, ALUCtrlOut, out_illegal}, 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_out_valid", out_valid, 0);
        next_cycle();

        // Directed decode vectors, one op at a time with out_ready high
        for (int i = 0; i < NV; i++) begin
            set_fields(vecs[i].opc, vecs[i].fn, vecs[i].sh, vecs[i].imm, vecs[i].rs, vecs[i].rt);
            in_valid = 1'b1;
            out_ready = 1'b1;
            next_cycle();
            in_valid = 1'b0;
            @(negedge clock);
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_op", i), {MuxOutA, MuxOutB, ALUCtrlOut, out_illegal},
                  {vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].ill});
            next_cycle();
        end
        @(negedge clock);
        check("vec_idle_out_valid", out_valid, 0);
        next_cycle();

        // Stall: ops 1..3 with out_ready low for two cycles
        set_add(32'd1, 32'd10); in_valid = 1'b1; out_ready = 1'b1;
        next_cycle();
        set_add(32'd2, 32'd20); out_ready = 1'b0;
        @(negedge clock);
        check("stall_first_out", {out_valid, MuxOutA}, {1'b1, 32'd1});
        check("stall_ready_one", in_ready, 1);
        next_cycle();
        set_add(32'd3, 32'd30);
        @(negedge clock);
        check("stall_ready_full", in_ready, 0);
        check("stall_hold", {out_valid, MuxOutA, MuxOutB}, {1'b1, 32'd1, 32'd10});
        next_cycle();
        out_ready = 1'b1;
        @(negedge clock);
        check("release_out1", {out_valid, MuxOutA}, {1'b1, 32'd1});
        next_cycle();
        @(negedge clock);
        check("release_out2", {out_valid, MuxOutA, MuxOutB}, {1'b1, 32'd2, 32'd20});
        check("release_ready", in_ready, 1);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clock);
        check("release_out3", {out_valid, MuxOutA, MuxOutB}, {1'b1, 32'd3, 32'd30});
        next_cycle();
        @(negedge clock);
        check("release_empty", out_valid, 0);
        next_cycle();

        // Flush while full, then flush with in_ready high: nothing may come out
        out_ready = 1'b0;
        set_add(32'd11, 32'd0); in_valid = 1'b1;
        next_cycle();
        set_add(32'd12, 32'd0);
        next_cycle();
        set_add(32'd13, 32'd0); flush = 1'b1;
        @(negedge clock);
        check("flush_full_ready", in_ready, 0);
        next_cycle();
        set_add(32'd14, 32'd0);
        @(negedge clock);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        next_cycle();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        check("flush_drop_input", out_valid, 0);
        repeat (3) next_cycle();

        // Reset while full discards both entries
        out_ready = 1'b0;
        set_add(32'd21, 32'd1); in_valid = 1'b1;
        next_cycle();
        set_add(32'd22, 32'd2);
        next_cycle();
        in_valid = 1'b0; reset = 1'b1;
        @(negedge clock);
        check("reset_mid_in_ready", in_ready, 0);
        next_cycle();
        @(negedge clock);
        check("reset_mid_cleared", {out_valid, MuxOutA, MuxOutB, ALUCtrlOut, out_illegal}, 0);
        next_cycle();
        reset = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        check("reset_mid_ready", in_ready, 1);
        repeat (2) next_cycle();

        // Random valid/ready traffic; upstream holds an op until accepted
        accepted = 0;
        cycles = 0;
        last_acc = 1'b0;
        in_valid = 1'b0;
        while (accepted < 10000 && cycles < 60000) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                if (in_valid) randomize_fields();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            last_acc = in_valid && in_ready;
            if (last_acc) accepted++;
            next_cycle();
            cycles++;
        end
        check("rand_accepted", accepted, 10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8 && sb.size() != 0; i++) begin
            @(negedge clock);
            #1;
        end
        check("drain_scoreboard_empty", sb.size(), 0);
        next_cycle();
        @(negedge clock);
        check("drain_out_valid", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered operand-select and ALU-control stage that sits directly upstream of the 32-bit ALU. It accepts decoded instruction fields and register-file read data over a valid/ready handshake and derives `ALUCtrlOut`, `MuxOutA` and `MuxOutB`, which feed the ALU unchanged. A two-entry skid buffer gives full throughput with no combinational `out_ready`→`in_ready` path.

## Interface
Parameters:
- `WIDTH`, 32, datapath width. Only 32 is supported.
- `ILLEGAL_CTRL`, 4'b1111, `ALUCtrlOut` code emitted for undecodable instructions.

Ports:
- `clock`  in  1  sole clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous kill of all buffered entries.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage can accept; equals `!skid_valid && !reset`.
- `opcode`  in  6  instruction opcode.
- `funct`  in  6  R-type function field.
- `shamt`  in  5  shift amount.
- `imm16`  in  16  I-type immediate.
- `rs_data`  in  32  register rs value.
- `rt_data`  in  32  register rt value.
- `out_valid`  out  1  outputs hold a valid operation.
- `out_ready`  in  1  downstream accepts.
- `MuxOutA`  out  32  ALU operand A.
- `MuxOutB`  out  32  ALU operand B.
- `ALUCtrlOut`  out  4  ALU operation code.
- `out_illegal`  out  1  entry decoded as illegal.

## Operation
- Decode for opcode 0, by `funct`:
  - 0x24 AND → 0000; 0x20 ADD → 0001; 0x22 SUB → 0010; 0x25 OR → 0011; 0x2A SLT → 1001. For all of these, A=`rs_data` and B=`rt_data`.
  - 0x00 SLL → 0101; 0x02 SRL → 0110; 0x03 SRA → 1000. For shifts, A=`{27'b0,shamt}` and B=`rt_data`.
- Decode for I-type:
  - 0x08 ADDI → 0001, A=`rs_data`, B=sign-extended `imm16`.
  - 0x0C ANDI → 0000, A=`rs_data`, B=zero-extended `imm16`.
- Any other opcode/funct → `ILLEGAL_CTRL`, `out_illegal`=1, A=B=0.
- Decode happens on the input side. Each entry stores {A, B, ctrl, illegal}, 69 bits.
- Buffer states (main = output register, skid = overflow register):
  - EMPTY: nothing buffered.
    - Accept → ONE.
  - ONE: main valid, skid empty.
    - Output taken with no accept → EMPTY.
    - Accept while the output is taken → ONE; main is reloaded from the input.
    - Accept while the output is stalled → TWO; the input goes to skid.
  - TWO: main and skid both valid; `in_ready`=0.
    - Output taken → ONE; skid moves to main.
- Accept = `in_valid && in_ready`. Transfer = `out_valid && out_ready`.
- `flush` → EMPTY next cycle and overrides everything. An input presented in the same cycle is dropped even if `in_ready`=1.
- While `out_valid`=1 and `out_ready`=0, the outputs are held stable.

## Timing
- Reset values:
  - `out_valid`=0, `MuxOutA`=0, `MuxOutB`=0, `ALUCtrlOut`=0, `out_illegal`=0, skid cleared.
  - `in_ready`=0 while `reset` is high and 1 on the first cycle after.
- Latency: an input accepted at edge N appears with `out_valid`=1 after edge N; data comes from a register.
- Throughput: one operation per cycle when `out_ready` is held at 1.
- `in_ready` is a function of register state and `reset` only, so there is no combinational path from `out_ready`.
- Reset or flush mid-stall discards both entries with no output transfer.
- When a stall releases in TWO, the skid entry is presented on the next cycle. Order is always preserved.

## Structure
- Package `alu_pkg`:
  - ALU control codes (`ALU_AND`, `ALU_ADD`, `ALU_SUB`, `ALU_OR`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`, `ALU_SLT`, `ALU_ILLEGAL`).
  - Opcode/funct constants.
  - Packed struct `alu_op_t` {A, B, ctrl, illegal}.
  - The same code constants are used when testing the ALU.
- Sub-module `alu_operand_decode`: purely combinational fields→`alu_op_t`. The top level holds the skid-buffer state machine.

## Test plan
- Reset then ADD with rs=5, rt=7 and `out_ready`=1 → the next cycle shows A=5, B=7, ctrl=0001, `out_valid`=1.
- ADDI with imm16=0xFFFF → B=0xFFFFFFFF. ANDI with imm16=0xFFFF → B=0x0000FFFF, ctrl=0000.
- SRA with shamt=4 and rt=0x80000000 → A=0x00000004, B=0x80000000, ctrl=1000. Opcode 0x23 → ctrl=1111 and `out_illegal`=1.
- Back-to-back stream of ops 1..3 with `out_ready`=0 for 2 cycles:
  - `in_ready` drops after the second accept.
  - On release, outputs appear in order 1, 2, 3 with no loss or duplication.
- Assert `flush` in state TWO with `in_valid`=1 → next cycle `out_valid`=0 and `in_ready`=1, and the flushed inputs never appear.
- Random valid/ready toggling over 10k ops → the output sequence equals the input sequence, compared against a decode model.
